// File: rtl/edge_det_pkg.sv
// Shared constants for the multi-channel edge detector.
//   - edge_mode_e : per-channel detect mode encoding
//   - *_DEF       : default parameter values used by edge_det_multi / edge_det_ch
package edge_det_pkg;

  localparam int N_CH_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

endpackage

// File: rtl/edge_det_ch.sv
// One edge-detect channel: synchroniser chain, previous-level flop,
// registered detect pulse and sticky "edge seen" flag.
// Ports:
//   clk, rst     clock, async active-high reset
//   sig          asynchronous level input
//   mode         edge_mode_e encoding (off / rise / fall / both)
//   clr          synchronous sticky clear
//   en           pulse enable (low during post-reset warm-up)
//   pe           one-cycle detect pulse (registered)
//   sticky       latched flag, set by pe, cleared by clr (set wins)
module edge_det_ch
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       clr,
  input  logic       en,
  output logic       pe,
  output logic       sticky
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pe_q, pe_d;
  logic                   sticky_q, sticky_d;
  logic                   s, rise_en, fall_en;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig};
    s        = sync_q[SYNC_STAGES-1];
    // prev keeps tracking s during warm-up so a level already high at
    // release is not mistaken for a rising edge once en goes high.
    prev_d   = s;
    rise_en  = (mode == MODE_RISE) || (mode == MODE_BOTH);
    fall_en  = (mode == MODE_FALL) || (mode == MODE_BOTH);
    pe_d     = en & ((s & ~prev_q & rise_en) | (~s & prev_q & fall_en));
    // A pulse visible this cycle beats a clear arriving in the same cycle.
    sticky_d = pe_q | (sticky_q & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pe_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      pe_q     <= pe_d;
      sticky_q <= sticky_d;
    end
  end

  assign pe     = pe_q;
  assign sticky = sticky_q;

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector with warm-up gating and a saturating
// aggregate edge counter.
// Ports:
//   clk, rst   clock, async active-high reset
//   sig        [N_CH]     asynchronous level inputs
//   mode       [2*N_CH]   per-channel mode, bits [2i+1:2i] for channel i
//   clr        [N_CH]     per-channel sticky clear
//   cnt_clr               clear of edge_cnt (loads this cycle's pulse count)
//   pe         [N_CH]     registered one-cycle detect pulses
//   sticky     [N_CH]     sticky edge-seen flags
//   edge_cnt   [CNT_W]    saturating total of pe pulses
//   ready                 high once warm-up after reset has completed
module edge_det_multi
  import edge_det_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   sig,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  input  logic              cnt_clr,
  output logic [N_CH-1:0]   pe,
  output logic [N_CH-1:0]   sticky,
  output logic [CNT_W-1:0]  edge_cnt,
  output logic              ready
);

  localparam int WU_W  = $clog2(SYNC_STAGES + 2);
  localparam int PC_W  = $clog2(N_CH + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [WU_W-1:0]  WU_DONE = WU_W'(SYNC_STAGES + 1);
  localparam logic [SUM_W-1:0] SAT     = SUM_W'({CNT_W{1'b1}});

  logic [WU_W-1:0]  wu_q, wu_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_ch #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .sig    (sig[i]),
      .mode   (mode[2*i +: 2]),
      .clr    (clr[i]),
      .en     (en),
      .pe     (pe[i]),
      .sticky (sticky[i])
    );
  end

  always_comb begin
    // Edges 1..SYNC_STAGES+1 after release are suppressed; the edge that
    // finds the counter at WU_DONE is the first allowed to pulse and the
    // one that raises ready.
    en      = (wu_q == WU_DONE);
    wu_d    = en ? wu_q : wu_q + 1'b1;
    ready_d = en;

    pc = '0;
    for (int i = 0; i < N_CH; i++) pc = pc + PC_W'(pe[i]);

    // Clear loads this cycle's pulses so no edge is lost across it.
    sum   = (cnt_clr ? '0 : SUM_W'(cnt_q)) + SUM_W'(pc);
    cnt_d = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wu_q    <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wu_q    <= wu_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign edge_cnt = cnt_q;
  assign ready    = ready_q;

endmodule
